// File: rtl/fano_pkg.sv
// Shared widths, types and the metric saturation helper for the Fano decoder datapath.
package fano_pkg;

  localparam int unsigned DEF_SOFT_W   = 4;
  localparam int unsigned DEF_METRIC_W = 8;

  typedef logic signed [DEF_SOFT_W-1:0]   soft_t;
  typedef logic signed [DEF_METRIC_W-1:0] metric_t;
  typedef logic [1:0]                     rib_t;

  // Clamp a signed value into the signed range of a width-bit metric.
  function automatic int sat_metric(input int value, input int unsigned width);
    int max_v;
    int min_v;
    max_v = (1 << (width - 1)) - 1;
    min_v = -(1 << (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// First-word-fall-through FIFO with synchronous flush; push when full and pop when empty are
// ignored.
module sym_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == (AW+1)'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the wrap.
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/branch_metric_unit.sv
// Fano branch metric unit: buffers soft symbol pairs and, per re-encoded branch pair, emits two
// biased, saturated branch metrics and the better hypothesis two cycles later.
module branch_metric_unit #(
  parameter int unsigned SOFT_W     = fano_pkg::DEF_SOFT_W,
  parameter int unsigned METRIC_W   = fano_pkg::DEF_METRIC_W,
  parameter int unsigned BIAS       = 2,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_flush,
  input  logic                            i_sym_vld,
  output logic                            o_sym_rdy,
  input  logic signed [SOFT_W-1:0]        i_sym_sys,
  input  logic signed [SOFT_W-1:0]        i_sym_par,
  input  logic                            i_rib_vld,
  input  logic [1:0]                      i_rib_0,
  input  logic [1:0]                      i_rib_1,
  output logic                            o_vld,
  output logic signed [METRIC_W-1:0]      o_metric_0,
  output logic signed [METRIC_W-1:0]      o_metric_1,
  output logic                            o_best,
  output logic                            o_underflow,
  output logic [$clog2(FIFO_DEPTH):0]     o_level
);

  import fano_pkg::*;

  localparam logic signed [SOFT_W+2:0] BiasExt = (SOFT_W+3)'(BIAS);

  logic                   fifo_full, fifo_empty;
  logic [2*SOFT_W-1:0]    fifo_head;
  logic                   push, pop;

  assign o_sym_rdy = !fifo_full;
  assign push      = i_sym_vld && !fifo_full;
  assign pop       = i_rib_vld && !fifo_empty;

  sym_fifo #(
    .Width (2 * SOFT_W),
    .Depth (FIFO_DEPTH)
  ) u_sym_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (i_flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({i_sym_sys, i_sym_par}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_level)
  );

  logic                       s1_vld_q, s1_vld_d;
  logic signed [SOFT_W-1:0]   s1_sys_q, s1_sys_d;
  logic signed [SOFT_W-1:0]   s1_par_q, s1_par_d;
  rib_t                       s1_rib0_q, s1_rib0_d;
  rib_t                       s1_rib1_q, s1_rib1_d;
  logic                       vld_q, vld_d;
  logic signed [METRIC_W-1:0] metric0_q, metric0_d;
  logic signed [METRIC_W-1:0] metric1_q, metric1_d;
  logic                       best_q, best_d;
  logic                       underflow_q, underflow_d;

  logic signed [SOFT_W:0]     sys_ext, par_ext;
  logic signed [SOFT_W:0]     c_sys0, c_par0, c_sys1, c_par1;
  logic signed [SOFT_W+2:0]   raw0, raw1;
  logic signed [METRIC_W-1:0] sat0, sat1;

  always_comb begin
    s1_vld_d  = pop && !i_flush;
    s1_sys_d  = s1_sys_q;
    s1_par_d  = s1_par_q;
    s1_rib0_d = s1_rib0_q;
    s1_rib1_d = s1_rib1_q;
    if (pop && !i_flush) begin
      s1_sys_d  = fifo_head[2*SOFT_W-1:SOFT_W];
      s1_par_d  = fifo_head[SOFT_W-1:0];
      s1_rib0_d = i_rib_0;
      s1_rib1_d = i_rib_1;
    end

    underflow_d = underflow_q;
    if (i_flush) begin
      underflow_d = 1'b0;
    end else if (i_rib_vld && fifo_empty) begin
      underflow_d = 1'b1;
    end
  end

  // A set code bit means the LLR counts against the hypothesis.
  always_comb begin
    sys_ext = {s1_sys_q[SOFT_W-1], s1_sys_q};
    par_ext = {s1_par_q[SOFT_W-1], s1_par_q};
    c_sys0  = s1_rib0_q[1] ? -sys_ext : sys_ext;
    c_par0  = s1_rib0_q[0] ? -par_ext : par_ext;
    c_sys1  = s1_rib1_q[1] ? -sys_ext : sys_ext;
    c_par1  = s1_rib1_q[0] ? -par_ext : par_ext;
    raw0    = (SOFT_W+3)'(c_sys0) + (SOFT_W+3)'(c_par0) - BiasExt;
    raw1    = (SOFT_W+3)'(c_sys1) + (SOFT_W+3)'(c_par1) - BiasExt;
    sat0    = METRIC_W'(sat_metric(int'(raw0), METRIC_W));
    sat1    = METRIC_W'(sat_metric(int'(raw1), METRIC_W));

    vld_d     = s1_vld_q && !i_flush;
    metric0_d = metric0_q;
    metric1_d = metric1_q;
    best_d    = best_q;
    if (s1_vld_q && !i_flush) begin
      metric0_d = sat0;
      metric1_d = sat1;
      best_d    = (sat1 > sat0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q    <= 1'b0;
      s1_sys_q    <= '0;
      s1_par_q    <= '0;
      s1_rib0_q   <= '0;
      s1_rib1_q   <= '0;
      vld_q       <= 1'b0;
      metric0_q   <= '0;
      metric1_q   <= '0;
      best_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_sys_q    <= s1_sys_d;
      s1_par_q    <= s1_par_d;
      s1_rib0_q   <= s1_rib0_d;
      s1_rib1_q   <= s1_rib1_d;
      vld_q       <= vld_d;
      metric0_q   <= metric0_d;
      metric1_q   <= metric1_d;
      best_q      <= best_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_vld       = vld_q;
  assign o_metric_0  = metric0_q;
  assign o_metric_1  = metric1_q;
  assign o_best      = best_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_branch_metric_unit.sv
// Directed bench for branch_metric_unit with a symbol/metric scoreboard; a second instance with
// 4-bit metrics exercises saturation on the same stimulus.
module tb_branch_metric_unit;

  localparam int BIAS = 2;

  typedef struct { int sys; int par; } sym_t;
  typedef struct { int m0a; int m1a; int besta; int m0b; int m1b; int bestb; } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic i_flush = 1'b0;
  logic i_sym_vld = 1'b0;
  logic signed [3:0] i_sym_sys = '0;
  logic signed [3:0] i_sym_par = '0;
  logic i_rib_vld = 1'b0;
  logic [1:0] i_rib_0 = '0;
  logic [1:0] i_rib_1 = '0;

  logic rdy_a, vld_a, best_a, under_a;
  logic signed [7:0] m0_a, m1_a;
  logic [4:0] level_a;
  logic rdy_b, vld_b, best_b, under_b;
  logic signed [3:0] m0_b, m1_b;
  logic [4:0] level_b;

  sym_t msym[$];
  exp_t exp_q[$];
  int   munder = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  branch_metric_unit #(.SOFT_W(4), .METRIC_W(8), .BIAS(BIAS), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_flush(i_flush), .i_sym_vld(i_sym_vld), .o_sym_rdy(rdy_a),
    .i_sym_sys(i_sym_sys), .i_sym_par(i_sym_par), .i_rib_vld(i_rib_vld), .i_rib_0(i_rib_0),
    .i_rib_1(i_rib_1), .o_vld(vld_a), .o_metric_0(m0_a), .o_metric_1(m1_a), .o_best(best_a),
    .o_underflow(under_a), .o_level(level_a)
  );

  branch_metric_unit #(.SOFT_W(4), .METRIC_W(4), .BIAS(BIAS), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_flush(i_flush), .i_sym_vld(i_sym_vld), .o_sym_rdy(rdy_b),
    .i_sym_sys(i_sym_sys), .i_sym_par(i_sym_par), .i_rib_vld(i_rib_vld), .i_rib_0(i_rib_0),
    .i_rib_1(i_rib_1), .o_vld(vld_b), .o_metric_0(m0_b), .o_metric_1(m1_b), .o_best(best_b),
    .o_underflow(under_b), .o_level(level_b)
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_metric(int sys, int par, logic [1:0] rib, int mw);
    int v, hi, lo;
    v  = (rib[1] ? -sys : sys) + (rib[0] ? -par : par) - BIAS;
    hi = (1 << (mw - 1)) - 1;
    lo = -(1 << (mw - 1));
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v;
  endfunction

  task automatic drive(input bit sv, input int sys, input int par, input bit rv,
                       input logic [1:0] r0, input logic [1:0] r1);
    i_sym_vld = sv;
    i_sym_sys = 4'(sys);
    i_sym_par = 4'(par);
    i_rib_vld = rv;
    i_rib_0   = r0;
    i_rib_1   = r1;
  endtask

  // Advance one clock, updating the model with what the DUT should accept on this edge.
  task automatic cycle();
    bit   push_ok;
    bit   pop_ok;
    sym_t s;
    exp_t e;
    push_ok = i_sym_vld && (msym.size() < 16);
    pop_ok  = i_rib_vld && (msym.size() != 0);
    if (i_flush) begin
      msym.delete();
      munder = 0;
    end else begin
      if (i_rib_vld && msym.size() == 0) munder = 1;
      if (pop_ok) begin
        s = msym.pop_front();
        e.m0a = exp_metric(s.sys, s.par, i_rib_0, 8);
        e.m1a = exp_metric(s.sys, s.par, i_rib_1, 8);
        e.besta = (e.m1a > e.m0a) ? 1 : 0;
        e.m0b = exp_metric(s.sys, s.par, i_rib_0, 4);
        e.m1b = exp_metric(s.sys, s.par, i_rib_1, 4);
        e.bestb = (e.m1b > e.m0b) ? 1 : 0;
        exp_q.push_back(e);
      end
      if (push_ok) begin
        s.sys = int'(i_sym_sys);
        s.par = int'(i_sym_par);
        msym.push_back(s);
      end
    end
    @(posedge clk);
    #1;
    check("level", int'(level_a), msym.size());
    check("sym_rdy", int'(rdy_a), (msym.size() < 16) ? 1 : 0);
    check("underflow", int'(under_a), munder);
    check("level_b", int'(level_b), msym.size());
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && (vld_a || vld_b)) begin
      check("vld_b_match", int'(vld_b), int'(vld_a));
      if (exp_q.size() == 0) begin
        check("unexpected_vld", int'(vld_a), 0);
      end else begin
        e = exp_q.pop_front();
        check("metric_0", int'(m0_a), e.m0a);
        check("metric_1", int'(m1_a), e.m1a);
        check("best", int'(best_a), e.besta);
        check("metric_0_w4", int'(m0_b), e.m0b);
        check("metric_1_w4", int'(m1_b), e.m1b);
        check("best_w4", int'(best_b), e.bestb);
      end
    end
  end

  initial begin
    int budget;
    drive(0, 0, 0, 0, 2'b00, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", int'(vld_a), 0);
    check("rst_m0", int'(m0_a), 0);
    check("rst_m1", int'(m1_a), 0);
    check("rst_best", int'(best_a), 0);
    check("rst_under", int'(under_a), 0);
    check("rst_level", int'(level_a), 0);
    check("rst_rdy", int'(rdy_a), 1);
    reset_n = 1'b1;

    // 1: basic metrics and two-cycle latency
    drive(1, 7, 7, 0, 2'b00, 2'b00); cycle();
    drive(0, 0, 0, 1, 2'b00, 2'b11); cycle();
    check("t1_lat_vld_early", int'(vld_a), 0);
    drive(0, 0, 0, 0, 2'b00, 2'b00); cycle();
    check("t1_vld", int'(vld_a), 1);
    check("t1_m0", int'(m0_a), 12);
    check("t1_m1", int'(m1_a), -16);
    check("t1_best", int'(best_a), 0);
    check("t1_level", int'(level_a), 0);
    cycle();
    check("t1_vld_pulse", int'(vld_a), 0);
    check("t1_hold_m0", int'(m0_a), 12);

    // 2: negative LLRs, saturation in the narrow instance
    drive(1, -8, -8, 0, 2'b00, 2'b00); cycle();
    drive(0, 0, 0, 1, 2'b00, 2'b10); cycle();
    drive(0, 0, 0, 0, 2'b00, 2'b00); cycle();
    check("t2_m0", int'(m0_a), -18);
    check("t2_m1", int'(m1_a), -2);
    check("t2_best", int'(best_a), 1);
    check("t2_m0_sat", int'(m0_b), -8);
    cycle();

    // 3: fill, overflow push ignored, back-to-back drain, then a second fill for wrap
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        drive(1, i - 8, 7 - i, 0, 2'b00, 2'b00); cycle();
      end
      check("t3_full_level", int'(level_a), 16);
      check("t3_full_rdy", int'(rdy_a), 0);
      drive(1, 5, 5, 0, 2'b00, 2'b00); cycle();
      check("t3_ovf_level", int'(level_a), 16);
      for (int i = 0; i < 16; i++) begin
        drive(0, 0, 0, 1, 2'(i + pass), 2'(i + 1)); cycle();
      end
      drive(0, 0, 0, 0, 2'b00, 2'b00);
      repeat (3) cycle();
    end

    // 4: rib on empty FIFO with same-cycle push, then flush
    drive(1, 3, -2, 1, 2'b01, 2'b10); cycle();
    check("t4_under", int'(under_a), 1);
    check("t4_level", int'(level_a), 1);
    drive(0, 0, 0, 0, 2'b00, 2'b00);
    repeat (2) cycle();
    i_flush = 1'b1; cycle();
    i_flush = 1'b0;
    check("t4_flush_level", int'(level_a), 0);
    check("t4_flush_under", int'(under_a), 0);
    cycle();

    // 5: simultaneous push and pop at level 3
    for (int i = 0; i < 3; i++) begin
      drive(1, i + 1, -i - 1, 0, 2'b00, 2'b00); cycle();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 6 - 3 * i, 2 * i - 5, 1, 2'(i), 2'(3 - i)); cycle();
      check("t5_level", int'(level_a), 3);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 2'(i + 1), 2'(i)); cycle();
    end
    drive(0, 0, 0, 0, 2'b00, 2'b00);
    repeat (3) cycle();

    // 6: asynchronous reset with a result in flight
    drive(1, 4, 4, 0, 2'b00, 2'b00); cycle();
    drive(0, 0, 0, 1, 2'b00, 2'b11); cycle();
    drive(0, 0, 0, 0, 2'b00, 2'b00);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_vld", int'(vld_a), 0);
    check("t6_level", int'(level_a), 0);
    check("t6_rdy", int'(rdy_a), 1);
    msym.delete();
    exp_q.delete();
    munder = 0;
    @(posedge clk);
    #1;
    check("t6_vld_held", int'(vld_a), 0);
    reset_n = 1'b1;
    repeat (4) cycle();

    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
